// File: rtl/result_dump_ctrl.sv
// result_dump_ctrl
//
// Readout stage for processor_top. Once the core raises done, this block walks
// the data-memory debug port over a fixed window of WORD_COUNT words starting at
// BASE_ADDR, and presents each word on a valid/ready stream together with its
// offset and a running checksum of the accepted words. A dump runs once per rising
// phase of done; the block re-arms only after done has been seen low.
//
// Parameters
//   DATA_W      data and address width
//   BASE_ADDR   first data-memory word address dumped
//   WORD_COUNT  number of consecutive words dumped (>= 1)
//   READ_LAT    rising edges from a mem_addr change to valid processor_out (>= 1)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   done           processor completion flag (level)
//   processor_out  memory read data from processor_top
//   mem_addr       memory read address to processor_top
//   out_data       dumped word
//   out_index      word offset (0..WORD_COUNT-1) of out_data
//   out_valid      out_data/out_index valid
//   out_ready      consumer accepts the presented word
//   checksum       mod-2^DATA_W sum of all words accepted in this dump
//   busy           dump in progress
//   dump_complete  all words of the dump accepted
//
// All outputs come straight from registers.

module result_dump_ctrl #(
  parameter int unsigned          DATA_W     = 32,
  parameter logic [DATA_W-1:0]    BASE_ADDR  = '0,
  parameter int unsigned          WORD_COUNT = 10,
  parameter int unsigned          READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] processor_out,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] checksum,
  output logic              busy,
  output logic              dump_complete
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;
  localparam logic [1:0] StFinish  = 2'd3;

  // Latency counter counts down the edges still to wait before sampling.
  localparam int unsigned        LatW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LatW-1:0]    LatInit = LatW'(READ_LAT - 1);
  localparam logic [DATA_W-1:0]  LastIdx = DATA_W'(WORD_COUNT - 1);
  localparam logic [DATA_W-1:0]  One     = DATA_W'(1);

  logic [1:0]        state_q, state_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              cmpl_q, cmpl_d;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    index_d = index_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    cmpl_d  = cmpl_q;

    case (state_q)
      StIdle: begin
        if (done) begin
          addr_d  = BASE_ADDR;
          idx_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
          lat_d   = LatInit;
          state_d = StWait;
        end
      end

      StWait: begin
        // Sample on the READ_LAT-th edge after the edge that moved mem_addr.
        if (lat_q == '0) begin
          data_d  = processor_out;
          index_d = idx_q;
          valid_d = 1'b1;
          state_d = StPresent;
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end

      StPresent: begin
        if (out_ready) begin
          sum_d   = sum_q + data_q;
          valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            busy_d  = 1'b0;
            cmpl_d  = 1'b1;
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + One;
            // Address wraps mod 2^DATA_W by construction.
            addr_d  = BASE_ADDR + idx_q + One;
            lat_d   = LatInit;
            state_d = StWait;
          end
        end
      end

      StFinish: begin
        // Hold results until done drops; checksum survives into idle.
        if (!done) begin
          cmpl_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      index_q <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      index_q <= index_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cmpl_q  <= cmpl_d;
    end
  end

  assign mem_addr      = addr_q;
  assign out_data      = data_q;
  assign out_index     = index_q;
  assign out_valid     = valid_q;
  assign checksum      = sum_q;
  assign busy          = busy_q;
  assign dump_complete = cmpl_q;

endmodule
